reg_file_wb: RTL and testbench

Architectural integer register file: the consumer end of the write-back interface. It commits the write-back stage's `rd_out`/`reg_we_out`/`write_data` triple and serves operands to decode/execute through two read ports. A registered debug read port with a request/valid handshake and a commit counter provide bench and debugger visibility. Sits between the write-back stage (write side) and the decode stage (read side) of the single-cycle core.

---
 rtl/reg_file_wb.sv | 71 +++++++
 tb/tb_reg_file_wb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// Architectural register file (x0 hardwired to zero) with two combinational read ports,
// optional write-to-read forwarding, a registered debug read port and a commit counter.
module reg_file_wb #(
    parameter int unsigned XLEN   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            dbg_req,
    input  logic [4:0]      dbg_addr,
    output logic            dbg_valid,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     wr_count
);

    logic [XLEN-1:0] r_regs [32];
    logic [XLEN-1:0] r_dbg_data;
    logic            r_dbg_valid;
    logic [31:0]     r_wr_count;

    logic            w_commit;
    logic            w_byp1;
    logic            w_byp2;
    logic [XLEN-1:0] w_dbg_val;

    assign w_commit = wb_we && (wb_rd != 5'd0);

    // Forwarding is gated by rst so the read ports show all zeros while reset is held.
    always_comb begin
        w_byp1    = BYPASS && !rst && w_commit && (wb_rd == rs1_addr);
        w_byp2    = BYPASS && !rst && w_commit && (wb_rd == rs2_addr);
        rs1_data  = (rs1_addr == 5'd0) ? '0 : (w_byp1 ? wb_data : r_regs[rs1_addr]);
        rs2_data  = (rs2_addr == 5'd0) ? '0 : (w_byp2 ? wb_data : r_regs[rs2_addr]);
        w_dbg_val = (dbg_addr == 5'd0) ? '0 :
                    ((w_commit && (wb_rd == dbg_addr)) ? wb_data : r_regs[dbg_addr]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i[4:0]] <= '0;
            end
            r_dbg_valid <= 1'b0;
            r_dbg_data  <= '0;
            r_wr_count  <= '0;
        end else begin
            if (w_commit) begin
                r_regs[wb_rd] <= wb_data;
                r_wr_count    <= r_wr_count + 32'd1;
            end
            if (dbg_req) begin
                r_dbg_valid <= 1'b1;
                r_dbg_data  <= w_dbg_val;
            end else begin
                r_dbg_valid <= 1'b0;
            end
        end
    end

    assign dbg_valid = r_dbg_valid;
    assign dbg_data  = r_dbg_data;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: both BYPASS settings driven in lockstep and
// compared against an array-based architectural model of the register file.
module tb_reg_file_wb;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            dbg_req;
    logic [4:0]      dbg_addr;

    logic [XLEN-1:0] b_rs1, b_rs2, b_dbg_data, n_rs1, n_rs2, n_dbg_data;
    logic            b_dbg_valid, n_dbg_valid;
    logic [31:0]     b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    bit [XLEN-1:0] m_regs [32];
    bit [31:0]     m_count;
    bit            m_dbg_valid;
    bit [XLEN-1:0] m_dbg_data;

    always #5 clk = ~clk;

    reg_file_wb #(.XLEN(XLEN), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .rs1_addr(rs1_addr), .rs1_data(b_rs1), .rs2_addr(rs2_addr), .rs2_data(b_rs2),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_valid(b_dbg_valid),
        .dbg_data(b_dbg_data), .wr_count(b_cnt)
    );

    reg_file_wb #(.XLEN(XLEN), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .rs1_addr(rs1_addr), .rs1_data(n_rs1), .rs2_addr(rs2_addr), .rs2_data(n_rs2),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_valid(n_dbg_valid),
        .dbg_data(n_dbg_data), .wr_count(n_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [XLEN-1:0] exp_read(input bit [4:0] a, input bit byp);
        if (a == 5'd0) return '0;
        if (byp && wb_we && (wb_rd == a)) return wb_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_count     = '0;
        m_dbg_valid = 1'b0;
        m_dbg_data  = '0;
    endtask

    // Apply inputs just after a falling edge and check the combinational read ports.
    task automatic drive(input bit we, input bit [4:0] rd, input bit [XLEN-1:0] data,
                         input bit [4:0] a1, input bit [4:0] a2,
                         input bit dreq, input bit [4:0] daddr);
        wb_we = we; wb_rd = rd; wb_data = data;
        rs1_addr = a1; rs2_addr = a2; dbg_req = dreq; dbg_addr = daddr;
        #1;
        check("byp_rs1", b_rs1, exp_read(a1, 1'b1));
        check("byp_rs2", b_rs2, exp_read(a2, 1'b1));
        check("nob_rs1", n_rs1, exp_read(a1, 1'b0));
        check("nob_rs2", n_rs2, exp_read(a2, 1'b0));
    endtask

    // One rising edge: advance the model, then check registered outputs at the falling edge.
    task automatic edge_check();
        @(posedge clk);
        if (dbg_req) begin
            m_dbg_valid = 1'b1;
            m_dbg_data  = (dbg_addr == 5'd0) ? '0 :
                          ((wb_we && wb_rd == dbg_addr) ? wb_data : m_regs[dbg_addr]);
        end else begin
            m_dbg_valid = 1'b0;
        end
        if (wb_we && wb_rd != 5'd0) begin
            m_regs[wb_rd] = wb_data;
            m_count       = m_count + 32'd1;
        end
        @(negedge clk);
        check("byp_dbg_valid", {31'd0, b_dbg_valid}, {31'd0, m_dbg_valid});
        check("nob_dbg_valid", {31'd0, n_dbg_valid}, {31'd0, m_dbg_valid});
        check("byp_dbg_data", b_dbg_data, m_dbg_data);
        check("nob_dbg_data", n_dbg_data, m_dbg_data);
        check("byp_wr_count", b_cnt, m_count);
        check("nob_wr_count", n_cnt, m_count);
    endtask

    initial begin
        rst = 1'b1;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
        model_reset();

        // Reset held: every address reads zero, registered outputs zero.
        #1;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            #1;
            check("rst_byp_rs1", b_rs1, 32'h0);
            check("rst_nob_rs1", n_rs1, 32'h0);
        end
        check("rst_dbg_valid", {31'd0, b_dbg_valid}, 32'd0);
        check("rst_dbg_data", b_dbg_data, 32'h0);
        check("rst_wr_count", b_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write/read.
        drive(1'b1, 5'd5, 32'h0000_0001, 5'd0, 5'd0, 1'b0, 5'd0);  edge_check();
        drive(1'b1, 5'd31, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 5'd0); edge_check();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0, 5'd0);
        check("basic_rs1", b_rs1, 32'h0000_0001);
        check("basic_rs2", n_rs2, 32'hDEAD_BEEF);
        edge_check();
        check("basic_count", b_cnt, 32'd2);

        // x0 protection.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0);
        check("x0_same_cycle", b_rs1, 32'h0);
        edge_check();
        check("x0_after_edge", b_rs1, 32'h0);
        check("x0_count", b_cnt, 32'd2);

        // Bypass behaviour in both configurations.
        drive(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0, 5'd0); edge_check();
        drive(1'b0, 5'd7, 32'h22, 5'd7, 5'd7, 1'b0, 5'd0);
        check("nowe_byp", b_rs1, 32'h11);
        check("nowe_nob", n_rs2, 32'h11);
        edge_check();
        drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 1'b0, 5'd0);
        check("byp_fwd", b_rs2, 32'h22);
        check("nob_old", n_rs1, 32'h11);
        edge_check();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
        check("nob_new", n_rs1, 32'h22);

        // Debug handshake, back-to-back.
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd5); edge_check();
        check("dbg0", b_dbg_data, 32'h1);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7); edge_check();
        check("dbg1", b_dbg_data, 32'h22);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0); edge_check();
        check("dbg2", n_dbg_data, 32'h0);
        check("dbg2_valid", {31'd0, n_dbg_valid}, 32'd1);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd5); edge_check();
        check("dbg_idle_valid", {31'd0, b_dbg_valid}, 32'd0);
        drive(1'b1, 5'd5, 32'h99, 5'd0, 5'd0, 1'b1, 5'd5); edge_check();
        check("dbg_same_edge", n_dbg_data, 32'h99);

        // Asynchronous reset mid-cycle with a debug result in flight.
        drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd5, 1'b1, 5'd9); edge_check();
        #2 rst = 1'b1;
        #1;
        check("arst_dbg_valid", {31'd0, b_dbg_valid}, 32'd0);
        check("arst_dbg_data", b_dbg_data, 32'h0);
        check("arst_count", n_cnt, 32'h0);
        check("arst_rs1", b_rs1, 32'h0);
        check("arst_rs2", n_rs2, 32'h0);
        model_reset();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hABCD; rs1_addr = 5'd3; dbg_req = 1'b0;
        #1;
        check("arst_wr_rs1", b_rs1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 1'b0, 5'd0);
        check("arst_no_commit", b_rs1, 32'h0);
        edge_check();
        drive(1'b1, 5'd4, 32'h4444, 5'd4, 5'd0, 1'b0, 5'd0); edge_check();
        check("post_rst_count", b_cnt, 32'd1);

        // Counter wrap via preload.
        force u_byp.r_wr_count = 32'hFFFF_FFFE;
        force u_nob.r_wr_count = 32'hFFFF_FFFE;
        #1;
        release u_byp.r_wr_count;
        release u_nob.r_wr_count;
        m_count = 32'hFFFF_FFFE;
        drive(1'b1, 5'd6, 32'h6, 5'd0, 5'd0, 1'b0, 5'd0); edge_check();
        check("wrap_ffff", b_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 5'd6, 32'h7, 5'd6, 5'd0, 1'b0, 5'd0); edge_check();
        check("wrap_zero", n_cnt, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b0, 5'd0);
        check("repeat_last", n_rs1, 32'h7);
        edge_check();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit [4:0] rd, a1, a2, da;
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            da = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), rd, $urandom, a1, a2,
                  1'($urandom_range(0, 1)), da);
            edge_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
